// File: rtl/psk_mod.sv
// BPSK/QPSK modulator: valid/ready symbol intake on the sample clock, PN or mute
// fill on underrun, and I/Q mixing against external cos/sin carriers.
module psk_mod #(
  parameter int CWIDTH = 16,
  parameter int SPS    = 1280,
  parameter int CNT_W  = (SPS > 1) ? $clog2(SPS) : 1
) (
  input  logic                     clk_sig,
  input  logic                     rst_n,
  input  logic                     en_sig,
  input  logic                     mode_sig,
  input  logic                     pn_fill_sig,
  input  logic [1:0]               data_sig,
  input  logic                     data_valid_sig,
  output logic                     data_ready_sig,
  input  logic signed [CWIDTH-1:0] carrier_i_sig,
  input  logic signed [CWIDTH-1:0] carrier_q_sig,
  output logic signed [CWIDTH+1:0] duc_sig,
  output logic                     sym_strobe_sig,
  output logic                     underrun_sig
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);

  logic [CNT_W-1:0]   cnt;
  logic signed [1:0]  sym_i, sym_q, nxt_i, nxt_q;
  logic [6:0]         lfsr, nxt_lfsr;
  logic               fresh;
  logic               boundary, xfer;

  function automatic logic signed [1:0] map_bit(input logic b);
    return b ? -2'sd1 : 2'sd1;
  endfunction

  // Level times carrier; levels are only -1/0/+1 so no multiplier is needed.
  function automatic logic signed [CWIDTH+1:0] scale(input logic signed [1:0] s,
                                                     input logic signed [CWIDTH-1:0] c);
    logic signed [CWIDTH+1:0] ext;
    ext = {{2{c[CWIDTH-1]}}, c};
    case (s)
      2'sd1:   return ext;
      -2'sd1:  return -ext;
      default: return '0;
    endcase
  endfunction

  assign boundary       = en_sig && (cnt == LAST);
  assign xfer           = boundary && data_valid_sig;
  assign data_ready_sig = boundary;

  always_comb begin
    nxt_i    = '0;
    nxt_q    = '0;
    nxt_lfsr = lfsr;
    if (xfer) begin
      if (mode_sig) begin
        nxt_i = map_bit(data_sig[1]);
        nxt_q = map_bit(data_sig[0]);
      end else begin
        nxt_i = map_bit(data_sig[0]);
      end
    end else if (pn_fill_sig) begin
      nxt_i = map_bit(lfsr[6]);
      if (mode_sig) begin
        // Two PN steps in one cycle: the second output bit is the current lfsr[5].
        nxt_q    = map_bit(lfsr[5]);
        nxt_lfsr = {lfsr[4:0], lfsr[6] ^ lfsr[5], lfsr[5] ^ lfsr[4]};
      end else begin
        nxt_lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      end
    end
  end

  always_ff @(posedge clk_sig or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      sym_i          <= '0;
      sym_q          <= '0;
      lfsr           <= 7'h7F;
      fresh          <= 1'b0;
      duc_sig        <= '0;
      sym_strobe_sig <= 1'b0;
      underrun_sig   <= 1'b0;
    end else if (en_sig) begin
      cnt            <= (cnt == LAST) ? '0 : cnt + 1'b1;
      duc_sig        <= scale(sym_i, carrier_i_sig) - scale(sym_q, carrier_q_sig);
      // fresh marks a symbol whose first mixed sample has not been emitted yet.
      sym_strobe_sig <= fresh;
      fresh          <= boundary;
      underrun_sig   <= boundary && !xfer;
      if (boundary) begin
        sym_i <= nxt_i;
        sym_q <= nxt_q;
        lfsr  <= nxt_lfsr;
      end
    end else begin
      duc_sig        <= '0;
      sym_strobe_sig <= 1'b0;
      underrun_sig   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_psk_mod.sv
// Random-stimulus bench for psk_mod at SPS=4 and SPS=1, checked against a
// symbol-level reference model driven by a precomputed PN bit sequence.
module tb_psk_mod;
  localparam int CW = 16;

  logic clk_sig = 1'b0;
  logic rst_n = 1'b0;
  logic en_sig = 1'b0, mode_sig = 1'b0, pn_fill_sig = 1'b0, data_valid_sig = 1'b0;
  logic [1:0] data_sig = '0;
  logic signed [CW-1:0] carrier_i_sig = '0, carrier_q_sig = '0;
  logic ready4, ready1, str4, str1, und4, und1;
  logic signed [CW+1:0] duc4, duc1;

  int n_cmp = 0, n_bad = 0;

  psk_mod #(.CWIDTH(CW), .SPS(4)) u_dut4 (
    .clk_sig(clk_sig), .rst_n(rst_n), .en_sig(en_sig), .mode_sig(mode_sig),
    .pn_fill_sig(pn_fill_sig), .data_sig(data_sig), .data_valid_sig(data_valid_sig),
    .data_ready_sig(ready4), .carrier_i_sig(carrier_i_sig), .carrier_q_sig(carrier_q_sig),
    .duc_sig(duc4), .sym_strobe_sig(str4), .underrun_sig(und4));

  psk_mod #(.CWIDTH(CW), .SPS(1)) u_dut1 (
    .clk_sig(clk_sig), .rst_n(rst_n), .en_sig(en_sig), .mode_sig(mode_sig),
    .pn_fill_sig(pn_fill_sig), .data_sig(data_sig), .data_valid_sig(data_valid_sig),
    .data_ready_sig(ready1), .carrier_i_sig(carrier_i_sig), .carrier_q_sig(carrier_q_sig),
    .duc_sig(duc1), .sym_strobe_sig(str1), .underrun_sig(und1));

  always #5 clk_sig = ~clk_sig;

  // PN output sequence of x^7+x^6+1 from seed 7F: a[n+7] = a[n] ^ a[n+1].
  bit pn [16384];
  int sps_of [2] = '{4, 1};
  int m_cnt [2], m_i [2], m_q [2], m_ptr [2];
  bit m_fresh [2];
  int exp_duc [2];
  bit exp_str [2], exp_und [2];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int map_b(input bit b);
    return b ? -1 : 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_i[k] = 0; m_q[k] = 0; m_ptr[k] = 0; m_fresh[k] = 0;
    end
  endtask

  task automatic model_edge(input int k);
    bit bnd, xf;
    bnd = en_sig && (m_cnt[k] == sps_of[k] - 1);
    xf  = bnd && data_valid_sig;
    exp_duc[k] = en_sig ? m_i[k] * int'(carrier_i_sig) - m_q[k] * int'(carrier_q_sig) : 0;
    exp_str[k] = en_sig && m_fresh[k];
    exp_und[k] = bnd && !xf;
    if (en_sig) begin
      m_fresh[k] = bnd;
      m_cnt[k] = (m_cnt[k] + 1) % sps_of[k];
    end
    if (bnd) begin
      if (xf) begin
        if (mode_sig) begin m_i[k] = map_b(data_sig[1]); m_q[k] = map_b(data_sig[0]); end
        else begin m_i[k] = map_b(data_sig[0]); m_q[k] = 0; end
      end else if (pn_fill_sig) begin
        m_i[k] = map_b(pn[m_ptr[k]]);
        if (mode_sig) begin m_q[k] = map_b(pn[m_ptr[k] + 1]); m_ptr[k] += 2; end
        else begin m_q[k] = 0; m_ptr[k] += 1; end
      end else begin
        m_i[k] = 0; m_q[k] = 0;
      end
    end
  endtask

  // Inputs are already driven; check ready, take one edge, check outputs.
  task automatic step();
    #1;
    chk("ready4", int'(ready4), int'(en_sig && m_cnt[0] == 3));
    chk("ready1", int'(ready1), int'(en_sig));
    @(posedge clk_sig);
    model_edge(0);
    model_edge(1);
    #1;
    chk("duc4", int'(duc4), exp_duc[0]);
    chk("str4", int'(str4), int'(exp_str[0]));
    chk("und4", int'(und4), int'(exp_und[0]));
    chk("duc1", int'(duc1), exp_duc[1]);
    chk("str1", int'(str1), int'(exp_str[1]));
    chk("und1", int'(und1), int'(exp_und[1]));
  endtask

  function automatic logic signed [CW-1:0] rnd_car();
    if ($urandom_range(7) == 0) return -16'sd32768;
    return CW'($urandom);
  endfunction

  initial begin
    for (int n = 0; n < 7; n++) pn[n] = 1'b1;
    for (int n = 0; n + 7 < 16384; n++) pn[n + 7] = pn[n] ^ pn[n + 1];
    model_reset();

    repeat (2) @(posedge clk_sig);
    #1;
    chk("rst_duc4", int'(duc4), 0);
    chk("rst_str4", int'(str4), 0);
    chk("rst_und4", int'(und4), 0);
    chk("rst_rdy4", int'(ready4), 0);
    rst_n = 1'b1;

    // Start-up: four mute samples, then +1000 with strobe on the fifth output.
    en_sig = 1; data_valid_sig = 1; data_sig = 2'b00; carrier_i_sig = 16'sd1000;
    for (int c = 0; c < 5; c++) step();
    chk("tp1_duc", int'(duc4), 1000);
    chk("tp1_str", int'(str4), 1);

    // Underrun with PN fill: first filled BPSK symbol is -1.
    data_valid_sig = 0; pn_fill_sig = 1;
    for (int c = 0; c < 8; c++) step();

    // Extreme QPSK: (-1)(-32768) - (+1)(-32768) = +65536.
    data_valid_sig = 1; mode_sig = 1; data_sig = 2'b10;
    carrier_i_sig = -16'sd32768; carrier_q_sig = -16'sd32768;
    for (int c = 0; c < 8; c++) step();
    chk("tp4_duc", int'(duc4), 65536);

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500 || c == 2401) begin
        #2 rst_n = 1'b0;
        #1;
        chk("arst_duc4", int'(duc4), 0);
        chk("arst_duc1", int'(duc1), 0);
        chk("arst_str4", int'(str4), 0);
        model_reset();
        @(negedge clk_sig);
        rst_n = 1'b1;
        #1;
      end
      en_sig         = ($urandom_range(9) != 0);
      data_valid_sig = $urandom_range(1);
      data_sig       = 2'($urandom);
      if ($urandom_range(15) == 0) mode_sig = ~mode_sig;
      if ($urandom_range(15) == 0) pn_fill_sig = ~pn_fill_sig;
      carrier_i_sig  = rnd_car();
      carrier_q_sig  = rnd_car();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
